// File: rtl/game_pace_ctrl_if.sv
// Game pacing bus: player event pulses in, pacing outputs for the speed counter back.
// Latency: wiring only. Backpressure: none, every signal is a single-cycle pulse or level.
// Three-line header also names the optional feature macro: PACE_MISS_EN (enables the miss input).
interface game_pace_ctrl_if;
    logic        start;
    logic        pause;
    logic        hit;
    logic        miss;
    logic        ms100;
    logic        enable;
    logic [1:0]  speed;
    logic [15:0] time_left;
    logic        game_over;
    logic [1:0]  state;

    modport master (
        output start, pause, hit, miss,
        input  ms100, enable, speed, time_left, game_over, state
    );

    modport slave (
        input  start, pause, hit, miss,
        output ms100, enable, speed, time_left, game_over, state
    );
endinterface

// File: rtl/game_pace_ctrl.sv
// Session FSM + 100 ms prescaler + hit-driven speed level; define PACE_MISS_EN to let misses lower speed.
// Latency: all outputs registered, every event is visible the cycle after the edge that samples it.
// Backpressure: none; pulses are sampled on every edge and never stalled or queued.
module game_pace_ctrl #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 10,
    parameter int GAME_TICKS     = 600,
    parameter int HITS_PER_LEVEL = 5
) (
    input  logic              clk,
    input  logic              rst,
    game_pace_ctrl_if.slave   bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int HW  = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_LEVEL - 1);
    localparam logic [15:0]   TICKS_LOAD = 16'(GAME_TICKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  presc;
    logic [HW-1:0]  hit_cnt;
    logic [15:0]    time_left;
    logic [1:0]     speed;
    logic           ms100, enable, game_over;
    logic           tick, terminal, load;
    logic           miss_eff;

`ifdef PACE_MISS_EN
    assign miss_eff = bus.miss;
`else
    assign miss_eff = 1'b0;
    logic  unused_miss;
    assign unused_miss = bus.miss;
`endif

    assign tick     = (state == RUN) && (presc == PRESC_LAST);
    assign terminal = tick && (time_left == 16'd1);
    assign load     = ((state == IDLE) || (state == DONE)) && bus.start;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Terminal strobe outranks a pause on the same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (terminal)  state_nxt = DONE;
                     else if (bus.pause) state_nxt = PAUSE;
            PAUSE:   if (bus.pause) state_nxt = RUN;
            DONE:    if (bus.start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc     <= '0;
            hit_cnt   <= '0;
            time_left <= '0;
            speed     <= '0;
            ms100     <= 1'b0;
            enable    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            ms100     <= tick;
            enable    <= (state_nxt == RUN);
            game_over <= (state_nxt == DONE);
            if (load) begin
                presc     <= '0;
                hit_cnt   <= '0;
                time_left <= TICKS_LOAD;
                speed     <= '0;
            end else if (state == RUN) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) time_left <= time_left - 16'd1;
                // A miss cancels any coincident hit.
                if (miss_eff) begin
                    hit_cnt <= '0;
                    if (speed != 2'd0) speed <= speed - 2'd1;
                end else if (bus.hit) begin
                    if (hit_cnt == HIT_LAST) begin
                        hit_cnt <= '0;
                        if (speed != 2'd2) speed <= speed + 2'd1;
                    end else begin
                        hit_cnt <= hit_cnt + HW'(1);
                    end
                end
            end
        end
    end

    assign bus.ms100     = ms100;
    assign bus.enable    = enable;
    assign bus.speed     = speed;
    assign bus.time_left = time_left;
    assign bus.game_over = game_over;
    assign bus.state     = state;
endmodule

// File: tb/tb_game_pace_ctrl.sv
// Scoreboard bench for game_pace_ctrl: directed scenarios then random pulses against a session-level model.
module tb_game_pace_ctrl;
    localparam int CLK_HZ = 100;
    localparam int TICK_HZ = 10;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int GT = 5;
    localparam int HPL = 3;
`ifdef PACE_MISS_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    typedef struct packed {
        logic        ms100;
        logic        enable;
        logic [1:0]  speed;
        logic [15:0] time_left;
        logic        game_over;
        logic [1:0]  state;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    game_pace_ctrl_if bus ();

    game_pace_ctrl #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .GAME_TICKS(GT), .HITS_PER_LEVEL(HPL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Session model: mode 0 idle, 1 run, 2 pause, 3 done; time derived from clocks spent running.
    int m_mode = 0, m_clks = 0, m_speed = 0, m_hits = 0, m_tl = 0;
    bit m_ms = 0;

    task automatic model_edge(input bit r, input bit s, input bit p, input bit h, input bit m);
        int  nmode;
        bit  miss_eff;
        miss_eff = m & MISS_EN;
        m_ms = 1'b0;
        if (!r) begin
            m_mode = 0; m_clks = 0; m_speed = 0; m_hits = 0; m_tl = 0;
            return;
        end
        case (m_mode)
            0, 3: if (s) begin
                m_mode = 1; m_clks = 0; m_speed = 0; m_hits = 0; m_tl = GT;
            end
            1: begin
                nmode = p ? 2 : 1;
                m_clks++;
                if (m_clks % DIV == 0) begin
                    m_ms = 1'b1;
                    m_tl = GT - m_clks / DIV;
                    if (m_tl == 0) nmode = 3;
                end
                if (miss_eff) begin
                    if (m_speed > 0) m_speed--;
                    m_hits = 0;
                end else if (h) begin
                    m_hits++;
                    if (m_hits == HPL) begin
                        m_hits = 0;
                        if (m_speed < 2) m_speed++;
                    end
                end
                m_mode = nmode;
            end
            2: if (p) m_mode = 1;
            default: m_mode = 0;
        endcase
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit h, input bit m);
        exp_t e;
        rst = r; bus.start = s; bus.pause = p; bus.hit = h; bus.miss = m;
        @(posedge clk);
        model_edge(r, s, p, h, m);
        e.ms100     = m_ms;
        e.enable    = (m_mode == 1);
        e.speed     = 2'(m_speed);
        e.time_left = 16'(m_tl);
        e.game_over = (m_mode == 3);
        e.state     = 2'(m_mode);
        sbq.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e, got;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = {bus.ms100, bus.enable, bus.speed, bus.time_left, bus.game_over, bus.state};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got ms100=%b en=%b spd=%0d tl=%0d go=%b st=%0d want ms100=%b en=%b spd=%0d tl=%0d go=%b st=%0d",
                         $time, got.ms100, got.enable, got.speed, got.time_left, got.game_over, got.state,
                         e.ms100, e.enable, e.speed, e.time_left, e.game_over, e.state);
            end
        end
    end

    initial begin
        bus.start = 0; bus.pause = 0; bus.hit = 0; bus.miss = 0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        // Full uninterrupted session
        step(1, 1, 0, 0, 0);
        idle(55);
        // Seven hits spaced three cycles apart
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 1, 0);
            idle(2);
        end
        idle(35);
        // Pause mid-interval, resume after 40 cycles
        step(1, 1, 0, 0, 0);
        idle(15);
        step(1, 0, 1, 0, 0);
        idle(40);
        step(1, 0, 1, 0, 0);
        idle(45);
        // Pause and hit coinciding with the terminal strobe
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 200 && !(m_mode == 1 && m_clks + 1 == GT * DIV); i++) idle(1);
        step(1, 0, 1, 1, 0);
        idle(3);
        step(1, 1, 1, 0, 0);
        idle(4);
        // Reset during RUN at speed 1
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0);
        idle(3);
        // Misses after reaching top speed, then hit+miss together
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1);
            idle(1);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 0);
        idle(5);
        // Random pulse traffic
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0);
        idle(2);
        @(negedge clk); #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
